// File: rtl/maple_rx_deframer.sv
// Maple Bus receive deframer: synchronises SDCKA/SDCKB, decodes start/data/end
// patterns into bytes, checks the XOR CRC and streams each frame as AXI-Stream beats.
module maple_rx_deframer #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int SYNC_STAGES        = 2,
  parameter int TIMEOUT_CYCLES     = 100000,
  parameter int CHECK_CRC          = 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            sdcka_in,
  input  logic                            sdckb_in,
  input  logic                            enable,
  output logic                            m_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            receiving,
  output logic                            crc_error,
  output logic                            frame_error,
  output logic                            overflow,
  output logic [15:0]                     frame_count
);
  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int NB = W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_FLUSH} state_t;
  state_t state_q, state_d;

  // Synchronisers reset to 1 so an idle (pulled-up) line produces no edges.
  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic a_lvl, b_lvl, a_fall, a_rise, b_fall, b_rise;

  always_ff @(posedge aclk) begin
    if (areset) begin
      a_sync <= '1;
      b_sync <= '1;
      a_lvl  <= 1'b1;
      b_lvl  <= 1'b1;
      a_fall <= 1'b0;
      a_rise <= 1'b0;
      b_fall <= 1'b0;
      b_rise <= 1'b0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], sdcka_in};
      b_sync <= {b_sync[SYNC_STAGES-2:0], sdckb_in};
      a_lvl  <= a_sync[SYNC_STAGES-1];
      b_lvl  <= b_sync[SYNC_STAGES-1];
      a_fall <= a_lvl & ~a_sync[SYNC_STAGES-1];
      a_rise <= ~a_lvl & a_sync[SYNC_STAGES-1];
      b_fall <= b_lvl & ~b_sync[SYNC_STAGES-1];
      b_rise <= ~b_lvl & b_sync[SYNC_STAGES-1];
    end
  end

  logic [2:0]    pulse_cnt;
  logic [2:0]    bit_idx;
  logic          phase_q;
  logic [7:0]    shreg;
  logic [7:0]    crc;
  logic          byte_seen;
  logic [W-1:0]  asm_data;
  logic [BW-1:0] asm_cnt;
  logic [W-1:0]  pend_data;
  logic          pend_valid;
  logic [TW-1:0] tmo_cnt;

  logic edge_any, timed_out, out_free;
  logic go_start, go_data, pulse_inc, sample, bit_val, ferr_d;
  logic fl_pend, fl_part, frame_done;
  logic [7:0]    byte_next;
  logic          byte_done, word_done, dp_load, ovf_d;
  logic [W-1:0]  asm_ins;
  logic [NB-1:0] strb_part;

  assign edge_any  = a_fall | a_rise | b_fall | b_rise;
  assign timed_out = !edge_any && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  // Handshake: a beat transfers when tvalid && tready; the register is free to
  // load when it is empty or its current beat transfers in the same cycle.
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign receiving = (state_q != S_IDLE);

  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    go_start   = 1'b0;
    go_data    = 1'b0;
    pulse_inc  = 1'b0;
    sample     = 1'b0;
    bit_val    = 1'b0;
    ferr_d     = 1'b0;
    fl_pend    = 1'b0;
    fl_part    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && a_fall && b_lvl) begin
          state_d  = S_START;
          go_start = 1'b1;
        end
      end
      S_START: begin
        if (b_fall && !a_lvl) pulse_inc = 1'b1;
        if (a_rise) begin
          if (pulse_cnt == 3'd4) begin
            state_d = S_DATA;
            go_data = 1'b1;
          end else begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (!phase_q) begin
          if (a_fall) begin
            sample  = 1'b1;
            bit_val = b_lvl;
          end
        end else if (b_fall) begin
          sample  = 1'b1;
          bit_val = a_lvl;
        end else if (a_rise) begin
          // End pattern: the phase-1 bit just taken is dropped, so the frame is
          // byte-aligned only if that bit was the first of a byte.
          state_d = S_END;
          ferr_d  = (bit_idx != 3'd1) || !byte_seen;
        end
      end
      S_END: begin
        if (b_rise && a_lvl) state_d = byte_seen ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (out_free) begin
          if (pend_valid) fl_pend = 1'b1;
          else if (asm_cnt != '0) fl_part = 1'b1;
          else if (m_axis_tvalid && m_axis_tlast) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end else if (!m_axis_tvalid) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_START || state_q == S_DATA || state_q == S_END) &&
        (!enable || timed_out)) begin
      state_d   = byte_seen ? S_FLUSH : S_IDLE;
      ferr_d    = 1'b1;
      sample    = 1'b0;
      go_data   = 1'b0;
      pulse_inc = 1'b0;
    end
  end

  assign byte_next = {shreg[6:0], bit_val};
  assign byte_done = sample && phase_q && (bit_idx == 3'd7);
  assign word_done = byte_done && (asm_cnt == BW'(NB - 1));
  assign asm_ins   = asm_data | (W'(byte_next) << {asm_cnt, 3'b000});
  assign dp_load   = word_done && pend_valid && out_free;
  assign ovf_d     = word_done && pend_valid && !out_free;

  always_comb begin
    strb_part = '0;
    for (int i = 0; i < NB; i++) strb_part[i] = (BW'(i) < asm_cnt);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pulse_cnt     <= '0;
      bit_idx       <= '0;
      phase_q       <= 1'b0;
      shreg         <= '0;
      crc           <= '0;
      byte_seen     <= 1'b0;
      asm_data      <= '0;
      asm_cnt       <= '0;
      pend_data     <= '0;
      pend_valid    <= 1'b0;
      tmo_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
      crc_error     <= 1'b0;
      frame_error   <= 1'b0;
      overflow      <= 1'b0;
      frame_count   <= '0;
    end else begin
      frame_error <= ferr_d;
      overflow    <= ovf_d;
      crc_error   <= frame_done && (CHECK_CRC != 0) && (crc != 8'h00);
      if (frame_done) frame_count <= frame_count + 16'd1;

      if (edge_any || state_q == S_IDLE || state_q == S_FLUSH) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + TW'(1);

      if (go_start) begin
        pulse_cnt <= '0;
        byte_seen <= 1'b0;
      end
      if (pulse_inc && pulse_cnt != 3'd7) pulse_cnt <= pulse_cnt + 3'd1;
      if (go_data) begin
        bit_idx    <= '0;
        phase_q    <= 1'b0;
        shreg      <= '0;
        crc        <= '0;
        byte_seen  <= 1'b0;
        asm_data   <= '0;
        asm_cnt    <= '0;
        pend_valid <= 1'b0;
      end

      if (sample) begin
        shreg   <= byte_next;
        phase_q <= ~phase_q;
        bit_idx <= bit_idx + 3'd1;
        if (byte_done) begin
          crc       <= crc ^ byte_next;
          byte_seen <= 1'b1;
          if (word_done) begin
            pend_data  <= asm_ins;
            pend_valid <= 1'b1;
            asm_data   <= '0;
            asm_cnt    <= '0;
          end else begin
            asm_data <= asm_ins;
            asm_cnt  <= asm_cnt + BW'(1);
          end
        end
      end

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (dp_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pend_data;
        m_axis_tstrb  <= '1;
        m_axis_tlast  <= 1'b0;
      end
      if (fl_pend) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pend_data;
        m_axis_tstrb  <= '1;
        m_axis_tlast  <= (asm_cnt == '0);
        pend_valid    <= 1'b0;
      end
      if (fl_part) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= asm_data;
        m_axis_tstrb  <= strb_part;
        m_axis_tlast  <= 1'b1;
        asm_data      <= '0;
        asm_cnt       <= '0;
      end
    end
  end
endmodule
